// File: rtl/isa_pkg.sv
// Shared RV32IM vocabulary: opcodes, funct fields, one-hot op indices,
// immediate formats and the decoded-entry layout used by decode and ALU.
package isa_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 47;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SRL_SRA = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // One-hot bit positions; the eight M ops are contiguous in funct3 order.
  localparam logic [5:0] IDX_LUI  = 6'd0,  IDX_AUIPC = 6'd1,  IDX_JAL   = 6'd2,  IDX_JALR  = 6'd3;
  localparam logic [5:0] IDX_BEQ  = 6'd4,  IDX_BNE   = 6'd5,  IDX_BLT   = 6'd6,  IDX_BGE   = 6'd7;
  localparam logic [5:0] IDX_BLTU = 6'd8,  IDX_BGEU  = 6'd9,  IDX_LB    = 6'd10, IDX_LH    = 6'd11;
  localparam logic [5:0] IDX_LW   = 6'd12, IDX_LBU   = 6'd13, IDX_LHU   = 6'd14, IDX_SB    = 6'd15;
  localparam logic [5:0] IDX_SH   = 6'd16, IDX_SW    = 6'd17, IDX_ADDI  = 6'd18, IDX_SLTI  = 6'd19;
  localparam logic [5:0] IDX_SLTIU= 6'd20, IDX_XORI  = 6'd21, IDX_ORI   = 6'd22, IDX_ANDI  = 6'd23;
  localparam logic [5:0] IDX_SLLI = 6'd24, IDX_SRLI  = 6'd25, IDX_SRAI  = 6'd26, IDX_ADD   = 6'd27;
  localparam logic [5:0] IDX_SUB  = 6'd28, IDX_SLL   = 6'd29, IDX_SLT   = 6'd30, IDX_SLTU  = 6'd31;
  localparam logic [5:0] IDX_XOR  = 6'd32, IDX_SRL   = 6'd33, IDX_SRA   = 6'd34, IDX_OR    = 6'd35;
  localparam logic [5:0] IDX_AND  = 6'd36, IDX_ECALL = 6'd37, IDX_EBREAK= 6'd38, IDX_MUL   = 6'd39;
  localparam logic [5:0] IDX_MULH = 6'd40, IDX_MULHSU= 6'd41, IDX_MULHU = 6'd42, IDX_DIV   = 6'd43;
  localparam logic [5:0] IDX_DIVU = 6'd44, IDX_REM   = 6'd45, IDX_REMU  = 6'd46;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH} imm_fmt_e;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} occ_e;

  typedef struct packed {
    logic [INSTR_W-1:0] onehot;
    logic               illegal;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
  } dec_entry_t;

  // Assemble the sign-extended immediate of the given format.
  function automatic logic [XLEN-1:0] make_imm(imm_fmt_e fmt, logic [31:0] w);
    case (fmt)
      FMT_I:   return {{20{w[31]}}, w[31:20]};
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   return {w[31:12], 12'b0};
      FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      FMT_SH:  return {27'b0, w[24:20]};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake/payload bundle of the decode stage.
interface decode_stage_if;
  import isa_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [XLEN-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_onehot;
  logic [4:0]         out_rs1;
  logic [4:0]         out_rs2;
  logic [4:0]         out_rd;
  logic [XLEN-1:0]    out_imm;
  logic [XLEN-1:0]    out_pc;
  logic               out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_onehot, out_rs1, out_rs2, out_rd, out_imm, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_onehot, out_rs1, out_rs2, out_rd, out_imm, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32IM word decoder: one-hot op, immediate, fields, illegal.
module decode_comb import isa_pkg::*; (
  input  logic [31:0]        instr_i,
  output logic [INSTR_W-1:0] onehot_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic               illegal_o
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] idx;
  logic       legal;
  imm_fmt_e   fmt;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];
  assign rd_o  = instr_i[11:7];

  // Classify the word; every opcode constant ends in 2'b11, so other low bits fall to default.
  always_comb begin
    idx   = '0;
    legal = 1'b1;
    fmt   = FMT_R;
    case (opc)
      OPC_LUI:   begin idx = IDX_LUI;   fmt = FMT_U; end
      OPC_AUIPC: begin idx = IDX_AUIPC; fmt = FMT_U; end
      OPC_JAL:   begin idx = IDX_JAL;   fmt = FMT_J; end
      OPC_JALR:  begin idx = IDX_JALR;  fmt = FMT_I; legal = (f3 == 3'b000); end
      OPC_BRANCH: begin
        fmt = FMT_B;
        case (f3)
          F3_BEQ:  idx = IDX_BEQ;
          F3_BNE:  idx = IDX_BNE;
          F3_BLT:  idx = IDX_BLT;
          F3_BGE:  idx = IDX_BGE;
          F3_BLTU: idx = IDX_BLTU;
          F3_BGEU: idx = IDX_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        fmt = FMT_I;
        case (f3)
          F3_LB:   idx = IDX_LB;
          F3_LH:   idx = IDX_LH;
          F3_LW:   idx = IDX_LW;
          F3_LBU:  idx = IDX_LBU;
          F3_LHU:  idx = IDX_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        fmt = FMT_S;
        case (f3)
          F3_SB:   idx = IDX_SB;
          F3_SH:   idx = IDX_SH;
          F3_SW:   idx = IDX_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        case (f3)
          F3_ADD_SUB: idx = IDX_ADDI;
          F3_SLT:     idx = IDX_SLTI;
          F3_SLTU:    idx = IDX_SLTIU;
          F3_XOR:     idx = IDX_XORI;
          F3_OR:      idx = IDX_ORI;
          F3_AND:     idx = IDX_ANDI;
          F3_SLL:     begin fmt = FMT_SH; idx = IDX_SLLI; legal = (f7 == F7_BASE); end
          default: begin
            fmt = FMT_SH;
            if (f7 == F7_BASE)     idx = IDX_SRLI;
            else if (f7 == F7_ALT) idx = IDX_SRAI;
            else                   legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        if (f7 == F7_MULDIV) begin
          idx = IDX_MUL + {3'b000, f3};
        end else if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD_SUB: idx = IDX_ADD;
            F3_SLL:     idx = IDX_SLL;
            F3_SLT:     idx = IDX_SLT;
            F3_SLTU:    idx = IDX_SLTU;
            F3_XOR:     idx = IDX_XOR;
            F3_SRL_SRA: idx = IDX_SRL;
            F3_OR:      idx = IDX_OR;
            default:    idx = IDX_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
          idx = IDX_SUB;
        end else if (f7 == F7_ALT && f3 == F3_SRL_SRA) begin
          idx = IDX_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_SYSTEM: begin
        // Only ECALL/EBREAK exist in RV32IM; CSR forms are rejected.
        fmt   = FMT_I;
        idx   = instr_i[20] ? IDX_EBREAK : IDX_ECALL;
        legal = (f3 == 3'b000) && (instr_i[19:15] == 5'd0) && (instr_i[11:7] == 5'd0)
                && (instr_i[31:21] == 11'd0);
      end
      default: legal = 1'b0;
    endcase
  end

  assign onehot_o  = legal ? ({{(INSTR_W-1){1'b0}}, 1'b1} << idx) : '0;
  assign imm_o     = legal ? make_imm(fmt, instr_i) : '0;
  assign illegal_o = ~legal;
endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: main register plus one-deep skid, flush to empty.
module decode_stage import isa_pkg::*; (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  decode_stage_if.slave bus
);
  occ_e       state_q, state_d;
  dec_entry_t main_q, main_d, skid_q, skid_d, dec;
  logic       in_ready_w, out_valid_w, in_xfer, out_xfer;

  decode_comb u_decode_comb (
    .instr_i   (bus.in_instr),
    .onehot_o  (dec.onehot),
    .imm_o     (dec.imm),
    .rs1_o     (dec.rs1),
    .rs2_o     (dec.rs2),
    .rd_o      (dec.rd),
    .illegal_o (dec.illegal)
  );
  assign dec.pc = bus.in_pc;

  assign in_xfer  = bus.in_valid && in_ready_w;
  assign out_xfer = out_valid_w && bus.out_ready;

  // State and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Occupancy transitions; flush overrides everything and drops the input word.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) begin state_d = ST_ONE; main_d = dec; end
        ST_ONE: begin
          if (in_xfer && out_xfer)  main_d = dec;
          else if (in_xfer)  begin state_d = ST_FULL; skid_d = dec; end
          else if (out_xfer) state_d = ST_EMPTY;
        end
        ST_FULL: if (out_xfer) begin state_d = ST_ONE; main_d = skid_q; end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags are decoded from the state register only, never from inputs.
  always_comb begin
    in_ready_w  = (state_q != ST_FULL);
    out_valid_w = (state_q != ST_EMPTY);
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_w;
  assign bus.out_onehot  = main_q.onehot;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_pc      = main_q.pc;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: mask/match ISA table plus a FIFO occupancy model.
module tb_decode_stage;
  import isa_pkg::*;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          idx;
    imm_fmt_e    fmt;
  } pat_t;

  typedef struct {
    logic [63:0] onehot;
    logic        illegal;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          n_out = 0;
  bit          m_rdy;
  logic [31:0] pc_ctr = 32'h100;
  pat_t        pats[$];
  exp_t        q[$];

  always #5 clk = ~clk;

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void addp(logic [31:0] m, logic [31:0] v, int idx, imm_fmt_e f);
    pat_t p;
    p.mask = m; p.match = v; p.idx = idx; p.fmt = f;
    pats.push_back(p);
  endfunction

  function automatic void build_table();
    addp(32'h7F, 32'h37, IDX_LUI, FMT_U);      addp(32'h7F, 32'h17, IDX_AUIPC, FMT_U);
    addp(32'h7F, 32'h6F, IDX_JAL, FMT_J);      addp(32'h707F, 32'h0067, IDX_JALR, FMT_I);
    addp(32'h707F, 32'h0063, IDX_BEQ, FMT_B);  addp(32'h707F, 32'h1063, IDX_BNE, FMT_B);
    addp(32'h707F, 32'h4063, IDX_BLT, FMT_B);  addp(32'h707F, 32'h5063, IDX_BGE, FMT_B);
    addp(32'h707F, 32'h6063, IDX_BLTU, FMT_B); addp(32'h707F, 32'h7063, IDX_BGEU, FMT_B);
    addp(32'h707F, 32'h0003, IDX_LB, FMT_I);   addp(32'h707F, 32'h1003, IDX_LH, FMT_I);
    addp(32'h707F, 32'h2003, IDX_LW, FMT_I);   addp(32'h707F, 32'h4003, IDX_LBU, FMT_I);
    addp(32'h707F, 32'h5003, IDX_LHU, FMT_I);  addp(32'h707F, 32'h0023, IDX_SB, FMT_S);
    addp(32'h707F, 32'h1023, IDX_SH, FMT_S);   addp(32'h707F, 32'h2023, IDX_SW, FMT_S);
    addp(32'h707F, 32'h0013, IDX_ADDI, FMT_I); addp(32'h707F, 32'h2013, IDX_SLTI, FMT_I);
    addp(32'h707F, 32'h3013, IDX_SLTIU, FMT_I); addp(32'h707F, 32'h4013, IDX_XORI, FMT_I);
    addp(32'h707F, 32'h6013, IDX_ORI, FMT_I);  addp(32'h707F, 32'h7013, IDX_ANDI, FMT_I);
    addp(32'hFE00707F, 32'h00001013, IDX_SLLI, FMT_SH);
    addp(32'hFE00707F, 32'h00005013, IDX_SRLI, FMT_SH);
    addp(32'hFE00707F, 32'h40005013, IDX_SRAI, FMT_SH);
    addp(32'hFE00707F, 32'h00000033, IDX_ADD, FMT_R);  addp(32'hFE00707F, 32'h40000033, IDX_SUB, FMT_R);
    addp(32'hFE00707F, 32'h00001033, IDX_SLL, FMT_R);  addp(32'hFE00707F, 32'h00002033, IDX_SLT, FMT_R);
    addp(32'hFE00707F, 32'h00003033, IDX_SLTU, FMT_R); addp(32'hFE00707F, 32'h00004033, IDX_XOR, FMT_R);
    addp(32'hFE00707F, 32'h00005033, IDX_SRL, FMT_R);  addp(32'hFE00707F, 32'h40005033, IDX_SRA, FMT_R);
    addp(32'hFE00707F, 32'h00006033, IDX_OR, FMT_R);   addp(32'hFE00707F, 32'h00007033, IDX_AND, FMT_R);
    addp(32'hFFFFFFFF, 32'h00000073, IDX_ECALL, FMT_I); addp(32'hFFFFFFFF, 32'h00100073, IDX_EBREAK, FMT_I);
    addp(32'hFE00707F, 32'h02000033, IDX_MUL, FMT_R);  addp(32'hFE00707F, 32'h02001033, IDX_MULH, FMT_R);
    addp(32'hFE00707F, 32'h02002033, IDX_MULHSU, FMT_R); addp(32'hFE00707F, 32'h02003033, IDX_MULHU, FMT_R);
    addp(32'hFE00707F, 32'h02004033, IDX_DIV, FMT_R);  addp(32'hFE00707F, 32'h02005033, IDX_DIVU, FMT_R);
    addp(32'hFE00707F, 32'h02006033, IDX_REM, FMT_R);  addp(32'hFE00707F, 32'h02007033, IDX_REMU, FMT_R);
  endfunction

  // Two's-complement reinterpretation of an n-bit field.
  function automatic logic [31:0] sx(logic [31:0] v, int n);
    if (v[n-1]) return v - (32'd1 << n);
    return v;
  endfunction

  function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] pc);
    exp_t e;
    e.onehot = 64'd0; e.illegal = 1'b1; e.imm = 32'd0; e.pc = pc;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    foreach (pats[i]) begin
      if ((w & pats[i].mask) == pats[i].match) begin
        e.illegal = 1'b0;
        e.onehot  = 64'd1 << pats[i].idx;
        case (pats[i].fmt)
          FMT_I:  e.imm = sx(w >> 20, 12);
          FMT_S:  e.imm = sx(((w >> 25) << 5) | ((w >> 7) & 32'h1F), 12);
          FMT_B:  e.imm = sx((((w >> 31) & 32'h1) << 12) | (((w >> 7) & 32'h1) << 11)
                             | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1), 13);
          FMT_U:  e.imm = w & 32'hFFFFF000;
          FMT_J:  e.imm = sx((((w >> 31) & 32'h1) << 20) | (((w >> 12) & 32'hFF) << 12)
                             | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1), 21);
          FMT_SH: e.imm = (w >> 20) & 32'h1F;
          default: e.imm = 32'd0;
        endcase
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_word();
    int          r = $urandom_range(0, 9);
    pat_t        p = pats[$urandom_range(0, pats.size() - 1)];
    logic [31:0] w = p.match | ($urandom() & ~p.mask);
    if (r >= 9)      w = (w & ~32'h3) | 32'($urandom_range(0, 2));
    else if (r >= 7) w = $urandom();
    return w;
  endfunction

  // Reference: the stage behaves as a FIFO of at most two decoded entries.
  always @(posedge clk) begin
    if (rst_n) begin
      m_rdy = (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && bus.out_ready) q.delete(0);
        if (bus.in_valid && m_rdy) q.push_back(ref_decode(bus.in_instr, bus.in_pc));
      end
    end
  end

  always @(negedge rst_n) q.delete();

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      if (q.size() > 0 && bus.out_valid) begin
        chk("onehot", 64'(bus.out_onehot), q[0].onehot);
        chk("illegal", 64'(bus.out_illegal), 64'(q[0].illegal));
        chk("rs1", 64'(bus.out_rs1), 64'(q[0].rs1));
        chk("rs2", 64'(bus.out_rs2), 64'(q[0].rs2));
        chk("rd", 64'(bus.out_rd), 64'(q[0].rd));
        chk("pc", 64'(bus.out_pc), 64'(q[0].pc));
        if (!q[0].illegal) chk("imm", 64'(bus.out_imm), 64'(q[0].imm));
        chk("popcount", 64'($countones(bus.out_onehot)), q[0].illegal ? 64'd0 : 64'd1);
        if (bus.out_ready && !flush) begin
          n_out++;
          $display("out %0d pc=%08h onehot=%012h imm=%08h ill=%0b", n_out, bus.out_pc,
                   bus.out_onehot, bus.out_imm, bus.out_illegal);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word until accepted; returns just after the accepting edge.
  task automatic offer(logic [31:0] w, logic [31:0] pc);
    bit done = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = w; bus.in_pc = pc;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk("offer_accepted", 64'(done), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic lit(string nm, logic [31:0] w, int idx, logic [31:0] imm);
    exp_t        e  = ref_decode(w, pc_ctr);
    logic [63:0] oh = (idx < 0) ? 64'd0 : (64'd1 << idx);
    bus.out_ready = 1'b1;
    offer(w, pc_ctr);
    pc_ctr += 4;
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({nm, "_onehot"}, 64'(bus.out_onehot), oh);
    chk({nm, "_illegal"}, 64'(bus.out_illegal), 64'(idx < 0));
    chk({nm, "_model_onehot"}, e.onehot, oh);
    if (idx >= 0) begin
      chk({nm, "_imm"}, 64'(bus.out_imm), 64'(imm));
      chk({nm, "_model_imm"}, 64'(e.imm), 64'(imm));
    end
  endtask

  logic [31:0] rw[8] = '{32'h002081B3, 32'h402081B3, 32'h022081B3, 32'h0020C1B3,
                         32'h4020D1B3, 32'h0220D1B3, 32'h0220F1B3, 32'h0020F1B3};
  int          ridx[8] = '{IDX_ADD, IDX_SUB, IDX_MUL, IDX_XOR, IDX_SRA, IDX_DIVU, IDX_REMU, IDX_AND};

  initial begin
    build_table();
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_onehot", 64'(bus.out_onehot), 64'd0);
    chk("rst_imm", 64'(bus.out_imm), 64'd0);
    #11 rst_n = 1'b1;
    step();

    // Directed decodes with hand-computed results.
    lit("addi", 32'hFFB10093, IDX_ADDI, 32'hFFFFFFFB);
    chk("addi_rs1", 64'(bus.out_rs1), 64'd2);
    chk("addi_rd", 64'(bus.out_rd), 64'd1);
    lit("beq", 32'hFE000EE3, IDX_BEQ, 32'hFFFFFFFC);
    lit("jal", 32'h001000EF, IDX_JAL, 32'h00000800);
    lit("lui", 32'h123452B7, IDX_LUI, 32'h12345000);
    lit("slli", 32'h00109093, IDX_SLLI, 32'h00000001);
    lit("zero_word", 32'h00000000, -1, 32'd0);
    lit("slli_b25", 32'h02109093, -1, 32'd0);
    step();

    // Eight back-to-back R-type ops at full throughput.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = rw[i]; bus.in_pc = pc_ctr; pc_ctr += 4;
      step();
      chk("stream_onehot", 64'(bus.out_onehot), 64'd1 << ridx[i]);
      chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    step();

    // Stall: two accepted, third held, then drain in order.
    bus.out_ready = 1'b0;
    offer(32'h00100093, 32'h1000);
    offer(32'h00200093, 32'h1004);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1; bus.in_instr = 32'h00300093; bus.in_pc = 32'h1008;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_pc", 64'(bus.out_pc), 64'h1000);
    end
    bus.out_ready = 1'b1;
    step();
    chk("drain_pc2", 64'(bus.out_pc), 64'h1004);
    step();
    chk("drain_pc3", 64'(bus.out_pc), 64'h1008);
    bus.in_valid = 1'b0;
    step();
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    // Flush while FULL with a simultaneous offer.
    bus.out_ready = 1'b0;
    offer(32'h00A00093, 32'h2000);
    offer(32'h00B00093, 32'h2004);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b1; bus.in_instr = 32'h00C00093; bus.in_pc = 32'h2008; flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    step(); step();
    chk("flush_no_ghost", 64'(bus.out_valid), 64'd0);

    // Flush while ONE with an input that would otherwise be accepted.
    bus.out_ready = 1'b0;
    offer(32'h00D00093, 32'h3000);
    bus.in_valid = 1'b1; bus.in_instr = 32'h00E00093; bus.in_pc = 32'h3004; flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_one_out_valid", 64'(bus.out_valid), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = gen_word();
      bus.in_pc     = pc_ctr;
      pc_ctr       += 4;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(); step(); step();

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    offer(32'hFFB10093, 32'h4000);
    offer(32'h123452B7, 32'h4004);
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("areset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("areset_onehot", 64'(bus.out_onehot), 64'd0);
    chk("areset_imm", 64'(bus.out_imm), 64'd0);
    chk("areset_pc", 64'(bus.out_pc), 64'd0);
    #10 rst_n = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32IM decode stage that sits directly upstream of the ALU.
- Accepts raw 32-bit instruction words plus PC from fetch.
- Produces the one-hot instruction vector that the ALU consumes, together with register specifiers, the sign-extended immediate and an illegal flag.
- Uses valid/ready handshakes on both sides, a 2-entry skid buffer for full throughput with registered in_ready, and a synchronous flush for branch redirect.

Parameters:
- INSTR_W, 47, width of the one-hot instruction vector; bit indices are fixed by the shared package.
- XLEN, 32, data/PC/immediate width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards every held and incoming instruction this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  registered; stage can accept an instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  ALU/issue consumes the entry.
- out_onehot  out  INSTR_W  exactly one bit set for a legal op, all zero if illegal.
- out_rs1  out  5  source register 1 specifier.
- out_rs2  out  5  source register 2 specifier.
- out_rd  out  5  destination register specifier.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  PC of the entry.
- out_illegal  out  1  opcode/funct combination not in RV32IM.

Behaviour:
- Reset (async assert, sync deassert edge): out_valid=0, in_ready=1, every data output 0, both buffer entries invalid.
- Decode is combinational on the input word; the result is written into a main register.
- Latency: 1 cycle. An instruction accepted at edge N is visible at the outputs after edge N.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* must be held stable while out_valid && !out_ready.
- Skid operation:
  - If main is valid, out_ready=0 and an input transfer occurs, the decoded entry goes to the skid register and in_ready drops to 0 on the next cycle.
  - When main drains, skid moves to main in that same edge and in_ready returns to 1.
  - Order is always preserved.
- Occupancy states:
  - EMPTY (in_ready=1, out_valid=0)
  - ONE (1,1)
  - FULL (0,1)
- State transitions:
  - EMPTY→ONE on input transfer.
  - ONE→EMPTY on output transfer only.
  - ONE stays ONE on simultaneous input and output transfer (new entry replaces main).
  - ONE→FULL on input transfer without output transfer.
  - FULL→ONE on output transfer (skid→main).
  - FULL cannot accept input.
- Throughput: one instruction per cycle while out_ready stays high.
- Flush:
  - The next state is EMPTY regardless of in_valid or out_ready that cycle.
  - The input word is dropped.
  - Flush has priority over every simultaneous event.
  - A flush during reset has no effect.
- Immediate formats (instr[31] is the sign bit):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: imm=0.
- Shift-immediate ops (SLLI/SRLI/SRAI):
  - imm = zero-extended shamt instr[24:20].
  - instr[25]=1 is illegal.
- Register fields: rs1/rs2/rd are always copied from bits [19:15]/[24:20]/[11:7]; the consumer ignores unused fields.
- Illegal instructions:
  - Unknown opcode, unknown funct3/funct7, or instr[1:0]≠2'b11.
  - Result: onehot=0, out_illegal=1; the entry still flows through the handshake normally.
- onehot invariant: popcount(out_onehot) equals 1 when !out_illegal, and 0 otherwise.

Decomposition:
- Shared package isa_pkg:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM).
  - funct3/funct7 constants.
  - INSTR_W.
  - named one-hot bit-index constants (IDX_ADD, IDX_SUB, IDX_ADDI, IDX_MUL, ...) shared with alu.
  - immediate-format enum.
- One natural sub-module: decode_comb, the purely combinational word→{onehot, imm, fields, illegal} decoder.
- decode_stage owns the handshake, skid and flush logic.

Test Plan:
- Reset then ADDI x1,x2,-5 (0xFFB10093) with out_ready=1 → one cycle later out_valid=1, onehot has only IDX_ADDI set, rs1=2, rd=1, imm=0xFFFFFFFB.
- Stream 8 back-to-back R-type ops (ADD, SUB, MUL, ...) with out_ready=1 → 8 outputs on 8 consecutive cycles in order, in_ready constantly 1, each onehot matches its IDX.
- Hold out_ready=0 and offer 3 instructions → 2 accepted, in_ready=0 after the second, third held. Then raise out_ready → order is 1,2,3 and out_* are stable during the stall.
- BEQ with offset −4 (0xFE000EE3) → imm=0xFFFFFFFC. JAL x1,+2048 → imm=0x00000800. LUI 0x12345 → imm=0x12345000.
- Word 0x00000000 and SLLI with instr[25]=1 → out_illegal=1, onehot=0, entry still delivered once.
- FULL state plus flush together with in_valid=1 → next cycle out_valid=0 and in_ready=1, no flushed entry ever appears. Then assert rst_n=0 mid-stream → outputs go to reset values immediately, without waiting for a clock edge.
